// File: rtl/load_store_unit.sv
// load_store_unit: bridges the execute stage and memory_axi. Every memory access is a full,
// word-aligned word. Sub-word loads are extracted and extended here; byte and half-word
// stores are done as read-modify-write because the memory always writes all four lanes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses complete
// immediately with o_Misaligned set instead of being truncated to an aligned access).
// Load/store type encodings mirror the LS_TYPE_* values used by memory_axi.
module load_store_unit #(
   parameter int XLEN         = 32,
   parameter int LS_SEL_WIDTH = 3
) (
   input  logic                    i_Clock,
   input  logic                    i_Reset,
   input  logic                    i_Valid,
   input  logic [LS_SEL_WIDTH:0]   i_Load_Store_Type,
   input  logic [XLEN-1:0]         i_Addr,
   input  logic [XLEN-1:0]         i_Store_Data,
   output logic [XLEN-1:0]         o_Load_Data,
   output logic                    o_Done,
   output logic                    o_Busy,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic                    o_Misaligned,
`endif
   output logic [LS_SEL_WIDTH:0]   o_Mem_Load_Store_Type,
   output logic                    o_Mem_Write_Enable,
   output logic [XLEN-1:0]         o_Mem_Addr,
   output logic [XLEN-1:0]         o_Mem_Data,
   input  logic [XLEN-1:0]         i_Mem_Data,
   input  logic                    i_Mem_Ready,
   input  logic                    i_Mem_Data_Valid
);

   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_NONE = (LS_SEL_WIDTH+1)'(0);
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LB   = (LS_SEL_WIDTH+1)'(1);
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LH   = (LS_SEL_WIDTH+1)'(2);
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LW   = (LS_SEL_WIDTH+1)'(3);
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LBU  = (LS_SEL_WIDTH+1)'(4);
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LHU  = (LS_SEL_WIDTH+1)'(5);
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SB   = (LS_SEL_WIDTH+1)'(6);
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SH   = (LS_SEL_WIDTH+1)'(7);
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SW   = (LS_SEL_WIDTH+1)'(8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_WR_WAIT,
      S_DONE
   } state_t;

   state_t                  r_State;
   logic [LS_SEL_WIDTH:0]   r_Type;
   logic [1:0]              r_Off;
   logic [XLEN-1:0]         r_Store_Data;
   logic [XLEN-1:0]         r_Load_Data;
   logic                    r_Done;
   logic                    r_Busy;
   logic [LS_SEL_WIDTH:0]   r_Mem_Type;
   logic                    r_Mem_WE;
   logic [XLEN-1:0]         r_Mem_Addr;
   logic [XLEN-1:0]         r_Mem_Data;
`ifdef LSU_MISALIGN_TRAP_EN
   logic                    r_Misaligned;
`endif

   logic                    w_In_Load;
   logic                    w_In_Store;
   logic                    w_Trap;
   logic [7:0]              w_Byte;
   logic [15:0]             w_Half;
   logic [XLEN-1:0]         w_Load_Ext;
   logic [XLEN-1:0]         w_Merge;

   // Classify the incoming request type.
   always_comb begin
      w_In_Load  = 1'b0;
      w_In_Store = 1'b0;
      case (i_Load_Store_Type)
         LS_TYPE_LB, LS_TYPE_LH, LS_TYPE_LW, LS_TYPE_LBU, LS_TYPE_LHU: w_In_Load  = 1'b1;
         LS_TYPE_SB, LS_TYPE_SH, LS_TYPE_SW:                           w_In_Store = 1'b1;
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   // A half access on an odd byte or a word access off a word boundary is trapped.
   always_comb begin
      w_Trap = 1'b0;
      case (i_Load_Store_Type)
         LS_TYPE_LH, LS_TYPE_LHU, LS_TYPE_SH: w_Trap = i_Addr[0];
         LS_TYPE_LW, LS_TYPE_SW:              w_Trap = (i_Addr[1:0] != 2'b00);
         default: ;
      endcase
   end
`else
   assign w_Trap = 1'b0;
`endif

   // Sub-word lanes of the returned word; half select ignores off[0].
   assign w_Byte = i_Mem_Data[8*r_Off +: 8];
   assign w_Half = i_Mem_Data[16*r_Off[1] +: 16];

   // Extend the selected lane into the load result.
   always_comb begin
      w_Load_Ext = i_Mem_Data;
      case (r_Type)
         LS_TYPE_LB:  w_Load_Ext = {{(XLEN-8){w_Byte[7]}}, w_Byte};
         LS_TYPE_LBU: w_Load_Ext = {{(XLEN-8){1'b0}}, w_Byte};
         LS_TYPE_LH:  w_Load_Ext = {{(XLEN-16){w_Half[15]}}, w_Half};
         LS_TYPE_LHU: w_Load_Ext = {{(XLEN-16){1'b0}}, w_Half};
         default: ;
      endcase
   end

   // Merge the store lanes into the word read back from memory.
   always_comb begin
      w_Merge = i_Mem_Data;
      case (r_Type)
         LS_TYPE_SB: w_Merge[8*r_Off +: 8]       = r_Store_Data[7:0];
         LS_TYPE_SH: w_Merge[16*r_Off[1] +: 16]  = r_Store_Data[15:0];
         default:    w_Merge                     = r_Store_Data;
      endcase
   end

   // Transaction FSM; every output is registered and updated on the transition into a state.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_State      <= S_IDLE;
         r_Type       <= LS_TYPE_NONE;
         r_Off        <= 2'b00;
         r_Store_Data <= '0;
         r_Load_Data  <= '0;
         r_Done       <= 1'b0;
         r_Busy       <= 1'b0;
         r_Mem_Type   <= LS_TYPE_NONE;
         r_Mem_WE     <= 1'b0;
         r_Mem_Addr   <= '0;
         r_Mem_Data   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_Misaligned <= 1'b0;
`endif
      end else begin
         case (r_State)
            S_IDLE: begin
               if (i_Valid && (w_In_Load || w_In_Store)) begin
                  r_Type       <= i_Load_Store_Type;
                  r_Off        <= i_Addr[1:0];
                  r_Store_Data <= i_Store_Data;
                  if (w_Trap) begin
                     r_State     <= S_DONE;
                     r_Done      <= 1'b1;
                     r_Load_Data <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                     r_Misaligned <= 1'b1;
`endif
                  end else if (i_Load_Store_Type == LS_TYPE_SW) begin
                     r_State    <= S_WR_REQ;
                     r_Busy     <= 1'b1;
                     r_Mem_Type <= LS_TYPE_SW;
                     r_Mem_WE   <= 1'b1;
                     r_Mem_Addr <= {i_Addr[XLEN-1:2], 2'b00};
                     r_Mem_Data <= i_Store_Data;
                  end else begin
                     // Loads and sub-word stores both start with a full-word read.
                     r_State    <= S_RD_REQ;
                     r_Busy     <= 1'b1;
                     r_Mem_Type <= LS_TYPE_LW;
                     r_Mem_WE   <= 1'b0;
                     r_Mem_Addr <= {i_Addr[XLEN-1:2], 2'b00};
                  end
               end
            end
            S_RD_REQ: begin
               if (i_Mem_Ready) begin
                  r_State <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (i_Mem_Data_Valid) begin
                  if ((r_Type == LS_TYPE_SB) || (r_Type == LS_TYPE_SH)) begin
                     r_State    <= S_WR_REQ;
                     r_Mem_Type <= LS_TYPE_SW;
                     r_Mem_WE   <= 1'b1;
                     r_Mem_Data <= w_Merge;
                  end else begin
                     r_State     <= S_DONE;
                     r_Load_Data <= w_Load_Ext;
                     r_Done      <= 1'b1;
                     r_Busy      <= 1'b0;
                     r_Mem_Type  <= LS_TYPE_NONE;
                  end
               end
            end
            S_WR_REQ: begin
               if (i_Mem_Ready) begin
                  r_State  <= S_WR_WAIT;
                  r_Mem_WE <= 1'b0;
               end
            end
            S_WR_WAIT: begin
               // Ready returning high means the memory has finished the write.
               if (i_Mem_Ready) begin
                  r_State    <= S_DONE;
                  r_Done     <= 1'b1;
                  r_Busy     <= 1'b0;
                  r_Mem_Type <= LS_TYPE_NONE;
               end
            end
            S_DONE: begin
               r_State <= S_IDLE;
               r_Done  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
               r_Misaligned <= 1'b0;
`endif
            end
            default: begin
               r_State <= S_IDLE;
            end
         endcase
      end
   end

   assign o_Load_Data           = r_Load_Data;
   assign o_Done                = r_Done;
   assign o_Busy                = r_Busy;
   assign o_Mem_Load_Store_Type = r_Mem_Type;
   assign o_Mem_Write_Enable    = r_Mem_WE;
   assign o_Mem_Addr            = r_Mem_Addr;
   assign o_Mem_Data            = r_Mem_Data;
`ifdef LSU_MISALIGN_TRAP_EN
   assign o_Misaligned          = r_Misaligned;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a small behavioural word
// memory. The stimulus pushes expected completions into a scoreboard queue; a monitor pops
// and compares whenever o_Done pulses. Honours LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

   localparam logic [3:0] T_NONE = 4'd0;
   localparam logic [3:0] T_LB   = 4'd1;
   localparam logic [3:0] T_LH   = 4'd2;
   localparam logic [3:0] T_LW   = 4'd3;
   localparam logic [3:0] T_LBU  = 4'd4;
   localparam logic [3:0] T_LHU  = 4'd5;
   localparam logic [3:0] T_SB   = 4'd6;
   localparam logic [3:0] T_SH   = 4'd7;
   localparam logic [3:0] T_SW   = 4'd8;
   localparam int         MemLat = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [3:0]  ls_type = T_NONE;
   logic [31:0] addr = '0;
   logic [31:0] sdata = '0;
   logic [31:0] load_data;
   logic        done;
   logic        busy;
   logic        mis;
   logic [3:0]  mem_type;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b1;
   logic        mem_dv = 1'b0;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32), .LS_SEL_WIDTH(3)) dut (
      .i_Clock               (clk),
      .i_Reset               (rst),
      .i_Valid               (valid),
      .i_Load_Store_Type     (ls_type),
      .i_Addr                (addr),
      .i_Store_Data          (sdata),
      .o_Load_Data           (load_data),
      .o_Done                (done),
      .o_Busy                (busy),
`ifdef LSU_MISALIGN_TRAP_EN
      .o_Misaligned          (mis),
`endif
      .o_Mem_Load_Store_Type (mem_type),
      .o_Mem_Write_Enable    (mem_we),
      .o_Mem_Addr            (mem_addr),
      .o_Mem_Data            (mem_wdata),
      .i_Mem_Data            (mem_rdata),
      .i_Mem_Ready           (mem_ready),
      .i_Mem_Data_Valid      (mem_dv)
   );
`ifndef LSU_MISALIGN_TRAP_EN
   assign mis = 1'b0;
`endif

   // Behavioural memory: ready when idle, fixed latency, read data returned as a one-cycle pulse.
   logic [31:0] mem [0:255];
   int          m_state = 0;
   int          m_cnt = 0;
   logic        m_wr = 1'b0;
   logic [7:0]  m_idx = '0;
   logic [31:0] m_wd = '0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;

   // Memory model sequencing.
   always @(posedge clk) begin
      if (rst) begin
         m_state   <= 0;
         mem_ready <= 1'b1;
         mem_dv    <= 1'b0;
      end else begin
         case (m_state)
            0: begin
               mem_dv <= 1'b0;
               if (mem_ready && (mem_type == T_LW)) begin
                  rd_cnt    <= rd_cnt + 1;
                  mem_ready <= 1'b0;
                  m_state   <= 1;
                  m_cnt     <= MemLat;
                  m_idx     <= mem_addr[9:2];
                  m_wr      <= 1'b0;
               end else if (mem_ready && (mem_type == T_SW) && mem_we) begin
                  wr_cnt    <= wr_cnt + 1;
                  mem_ready <= 1'b0;
                  m_state   <= 1;
                  m_cnt     <= MemLat;
                  m_idx     <= mem_addr[9:2];
                  m_wd      <= mem_wdata;
                  m_wr      <= 1'b1;
               end
            end
            1: begin
               if (m_cnt > 1) begin
                  m_cnt <= m_cnt - 1;
               end else if (m_wr) begin
                  mem[m_idx] <= m_wd;
                  mem_ready  <= 1'b1;
                  m_state    <= 0;
               end else begin
                  mem_rdata <= mem[m_idx];
                  mem_dv    <= 1'b1;
                  m_state   <= 2;
               end
            end
            default: begin
               mem_dv    <= 1'b0;
               mem_ready <= 1'b1;
               m_state   <= 0;
            end
         endcase
      end
   end

   typedef struct {
      logic        is_load;
      logic [31:0] data;
      int          reads;
      int          writes;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   exp_r = 0;
   int   exp_w = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%08h, required 0x%08h", nm, act, req);
      end
   endtask

   // Issue one request, check busy while it is outstanding, wait (bounded) for completion.
   task automatic do_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] sd,
                        input logic is_ld, input logic [31:0] exp_d, input int dr, input int dw,
                        input logic exp_mis);
      exp_t e;
      exp_r += dr;
      exp_w += dw;
      e.is_load = is_ld;
      e.data    = exp_d;
      e.reads   = exp_r;
      e.writes  = exp_w;
      e.mis     = exp_mis;
      sb_q.push_back(e);
      @(negedge clk);
      valid = 1'b1; ls_type = t; addr = a; sdata = sd;
      @(negedge clk);
      // Inputs are free to change once accepted.
      valid = 1'b0; ls_type = T_NONE; addr = $urandom; sdata = $urandom;
      for (int k = 0; k < 60; k++) begin
         if (done) break;
         chk("busy_while_active", {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
   endtask

   // Scoreboard monitor: compares each completion against the oldest expectation.
   logic prev_done = 1'b0;
   logic prev_dv = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
            if (sb_q.size() == 0) begin
               chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("busy_low_at_done", {31'd0, busy}, 32'd0);
               if (e.is_load) chk("load_data", load_data, e.data);
               if (e.is_load && !e.mis) chk("done_after_dv", {31'd0, prev_dv}, 32'd1);
               chk("mem_reads", rd_cnt, e.reads);
               chk("mem_writes", wr_cnt, e.writes);
`ifdef LSU_MISALIGN_TRAP_EN
               chk("misaligned", {31'd0, mis}, {31'd0, e.mis});
`endif
            end
         end
         prev_done = done;
         prev_dv   = mem_dv;
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_mis"}, {31'd0, mis}, 32'd0);
      chk({tag, "_load_data"}, load_data, 32'd0);
      chk({tag, "_mem_type"}, {28'd0, mem_type}, {28'd0, T_NONE});
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_data"}, mem_wdata, 32'd0);
   endtask

   // Directed stimulus.
   initial begin
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Arguments: type, addr, store data, is_load, expected load data, reads, writes, misaligned
      do_op(T_SW,  32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        0, 1, 1'b0);
      do_op(T_LW,  32'h100, 32'h0,        1'b1, 32'hDEADBEEF, 1, 0, 1'b0);
      do_op(T_LB,  32'h103, 32'h0,        1'b1, 32'hFFFFFFDE, 1, 0, 1'b0);
      do_op(T_LBU, 32'h103, 32'h0,        1'b1, 32'h000000DE, 1, 0, 1'b0);
      do_op(T_LH,  32'h102, 32'h0,        1'b1, 32'hFFFFDEAD, 1, 0, 1'b0);
      do_op(T_LHU, 32'h100, 32'h0,        1'b1, 32'h0000BEEF, 1, 0, 1'b0);
      do_op(T_LB,  32'h100, 32'h0,        1'b1, 32'hFFFFFFEF, 1, 0, 1'b0);
      do_op(T_LBU, 32'h101, 32'h0,        1'b1, 32'h000000BE, 1, 0, 1'b0);
      do_op(T_SW,  32'h104, 32'h11223344, 1'b0, 32'h0,        0, 1, 1'b0);
      do_op(T_SB,  32'h105, 32'hAABBCC55, 1'b0, 32'h0,        1, 1, 1'b0);
      do_op(T_LW,  32'h104, 32'h0,        1'b1, 32'h11225544, 1, 0, 1'b0);
      do_op(T_SW,  32'h200, 32'hCAFEF00D, 1'b0, 32'h0,        0, 1, 1'b0);
      do_op(T_LW,  32'h200, 32'h0,        1'b1, 32'hCAFEF00D, 1, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      do_op(T_SH,  32'h201, 32'h12349876, 1'b0, 32'h0,        0, 0, 1'b1);
      do_op(T_LW,  32'h200, 32'h0,        1'b1, 32'hCAFEF00D, 1, 0, 1'b0);
      do_op(T_SH,  32'h202, 32'h0000BEAD, 1'b0, 32'h0,        1, 1, 1'b0);
      do_op(T_LW,  32'h200, 32'h0,        1'b1, 32'hBEADF00D, 1, 0, 1'b0);
      do_op(T_LW,  32'h203, 32'h0,        1'b1, 32'h00000000, 0, 0, 1'b1);
      do_op(T_LH,  32'h203, 32'h0,        1'b1, 32'h00000000, 0, 0, 1'b1);
`else
      // Misaligned half store is truncated to lanes 0-1.
      do_op(T_SH,  32'h201, 32'h12349876, 1'b0, 32'h0,        1, 1, 1'b0);
      do_op(T_LW,  32'h200, 32'h0,        1'b1, 32'hCAFE9876, 1, 0, 1'b0);
      do_op(T_SH,  32'h202, 32'h0000BEAD, 1'b0, 32'h0,        1, 1, 1'b0);
      do_op(T_LW,  32'h200, 32'h0,        1'b1, 32'hBEAD9876, 1, 0, 1'b0);
      do_op(T_LW,  32'h203, 32'h0,        1'b1, 32'hBEAD9876, 1, 0, 1'b0);
      do_op(T_LH,  32'h203, 32'h0,        1'b1, 32'hFFFFBEAD, 1, 0, 1'b0);
`endif

      // Reset while waiting for read data, then confirm a clean follow-up load.
      @(negedge clk);
      valid = 1'b1; ls_type = T_LW; addr = 32'h100;
      @(negedge clk);
      valid = 1'b0; ls_type = T_NONE;
      @(negedge clk);
      chk("rd_wait_busy", {31'd0, busy}, 32'd1);
      chk("rd_wait_mem_type", {28'd0, mem_type}, {28'd0, T_LW});
      exp_r += 1;
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midreset");
      rst = 1'b0;
      do_op(T_LW,  32'h100, 32'h0,        1'b1, 32'hDEADBEEF, 1, 0, 1'b0);
      do_op(T_SB,  32'h100, 32'h00000080, 1'b0, 32'h0,        1, 1, 1'b0);
      do_op(T_LB,  32'h100, 32'h0,        1'b1, 32'hFFFFFF80, 1, 0, 1'b0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
